nl_output_buffer: RTL and testbench
===================================

NL_OUTPUT_BUFFER -- requirements
Module: nl_output_buffer

Interface
REQ-001 SHALL take N_DIM_ARRAY, INPUT_CHANNEL_DATA_WIDTH, INPUT_CHANNEL_ADDR_SIZE and NL_OUTBUF_DEPTH (default 8, power of two; FIFO depth in N-lane entries) from package parameters.
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports clk and reset.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 enable_nonlinear_block  in  1  start of a nonlinear/pooling pass.
REQ-006 wr_en_output_buffer_nl  in  1  producer write strobe.
REQ-007 wr_addr_nl  in  INPUT_CHANNEL_ADDR_SIZE  producer-relative word address.
REQ-008 output_word  in  N_DIM_ARRAY x INPUT_CHANNEL_DATA_WIDTH signed  lanes to store.
REQ-009 finished_activation  in  1  producer has issued its last write.
REQ-010 OUTPUT_BASE_ADDR  in  INPUT_CHANNEL_ADDR_SIZE  activation-memory base of the result.
REQ-011 mem_ready  in  1  activation memory accepts a write this cycle.
REQ-012 mem_wr_en  out  1  write request to activation memory.
REQ-013 mem_wr_addr  out  INPUT_CHANNEL_ADDR_SIZE  OUTPUT_BASE_ADDR + stored wr_addr_nl.
REQ-014 mem_wr_data  out  N_DIM_ARRAY x INPUT_CHANNEL_DATA_WIDTH signed  FIFO head lanes.
REQ-015 buffer_full, buffer_empty  out  1 each  FIFO status.
REQ-016 overflow  out  1  sticky: a write was dropped.
REQ-017 buffer_done  out  1  one-cycle pulse, pass fully drained.

Function
REQ-018 FSM states SHALL be IDLE, COLLECT, DRAIN, DONE.
REQ-019 IDLE->COLLECT on enable_nonlinear_block=1; enable in any other state SHALL be ignored.
REQ-020 COLLECT->DRAIN on the first cycle finished_activation=1; a write in that same cycle SHALL still be accepted.
REQ-021 DRAIN->DONE when buffer_empty=1 and no write is accepted that cycle; DONE->IDLE unconditionally after one cycle, buffer_done=1 only in DONE.
REQ-022 Write accepted iff wr_en_output_buffer_nl=1, state is COLLECT or DRAIN, and buffer_full=0 at cycle start; a pop in the same cycle SHALL NOT free space for it.
REQ-023 Write with buffer_full=1 SHALL be dropped and set overflow; overflow clears only on reset or IDLE->COLLECT.
REQ-024 Writes in IDLE or DONE SHALL be ignored without setting overflow.
REQ-025 mem_wr_en = !buffer_empty and state in {COLLECT, DRAIN}; pop occurs iff mem_wr_en and mem_ready.
REQ-026 mem_wr_addr/mem_wr_data SHALL stay stable while mem_wr_en=1 and mem_ready=0.
REQ-027 No bypass: a word written into an empty FIFO SHALL appear on mem_wr_* the next cycle (latency 1).
REQ-028 Simultaneous push and pop with neither full nor empty SHALL keep occupancy unchanged.
REQ-029 mem_wr_addr addition SHALL wrap modulo 2^INPUT_CHANNEL_ADDR_SIZE.
REQ-030 Read/write pointers SHALL wrap at NL_OUTBUF_DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-031 Entries SHALL be drained in write order.

Reset
REQ-032 Reset SHALL force state IDLE, pointers and occupancy 0, overflow 0; outputs: mem_wr_en 0, mem_wr_addr 0, mem_wr_data all 0, buffer_full 0, buffer_empty 1, buffer_done 0.
REQ-033 Reset mid-pass SHALL discard all buffered entries with no further mem_wr_en.

Configuration
REQ-034 With NL_OUTBUF_RELU_EN defined, each lane of mem_wr_data SHALL be clamped to 0 when negative (ReLU on the drain path, combinational, no added latency).
REQ-035 Without NL_OUTBUF_RELU_EN, mem_wr_data SHALL equal the stored lanes bit-exactly.

Structure
REQ-036 NL_OUTBUF_DEPTH and the FSM state enum typedef SHALL live in package parameters beside the existing array/width constants.
REQ-037 Storage and pointers SHALL be a sub-module nl_outbuf_fifo (push, pop, data+addr in, head out, full, empty); FSM, overflow and address offset stay in nl_output_buffer.

Verification
REQ-038 enable, 3 writes (addr 0,1,2, lane0=5,-3,7), mem_ready=1, finished on 3rd write -> mem_wr_addr BASE+0..2 each 1 cycle after its write, buffer_done pulse once.
REQ-039 mem_ready=0, 9 writes at DEPTH=8 -> buffer_full=1 after 8, 9th dropped, overflow=1; then mem_ready=1 -> exactly 8 ordered writes.
REQ-040 Full FIFO with simultaneous pop and push -> push dropped, overflow=1, occupancy 7.
REQ-041 OUTPUT_BASE_ADDR=max address, wr_addr_nl=2 -> mem_wr_addr=1 (wrap).
REQ-042 Lane value -4: with NL_OUTBUF_RELU_EN -> 0; without -> -4.
REQ-043 Reset asserted mid-DRAIN with 4 entries -> all outputs at reset values, buffer_empty=1, no mem_wr_en after release.

Source files
------------

// File: rtl/nl_output_buffer_pkg.sv
// ----------------------------------------------------------------------------
// parameters -- shared constants and types for the nonlinear output buffer.
//
// Holds the array/width constants, the output-buffer depth, the derived
// pointer/occupancy widths, the lane/word/address types and the FSM state
// enum used by nl_output_buffer, nl_outbuf_fifo and nl_output_buffer_if.
// NL_OUTBUF_DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
package parameters;

    localparam int N_DIM_ARRAY              = 4;
    localparam int INPUT_CHANNEL_DATA_WIDTH = 8;
    localparam int INPUT_CHANNEL_ADDR_SIZE  = 8;

    // FIFO depth in N-lane entries.
    localparam int NL_OUTBUF_DEPTH = 8;
    localparam int NL_OUTBUF_PTR_W = $clog2(NL_OUTBUF_DEPTH);
    localparam int NL_OUTBUF_CNT_W = NL_OUTBUF_PTR_W + 1;

    typedef logic signed [INPUT_CHANNEL_DATA_WIDTH-1:0] lane_t;
    typedef lane_t [N_DIM_ARRAY-1:0]                    word_t;
    typedef logic [INPUT_CHANNEL_ADDR_SIZE-1:0]         addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } nl_state_t;

endpackage

// File: rtl/nl_output_buffer_if.sv
// ----------------------------------------------------------------------------
// nl_output_buffer_if -- activation-memory write bus.
//
// Signals:
//   mem_wr_en    write request (buffer -> memory)
//   mem_wr_addr  absolute activation-memory word address
//   mem_wr_data  N lanes of signed data
//   mem_ready    memory accepts the write this cycle (memory -> buffer)
// Modports: master (the output buffer), slave (the activation memory).
// ----------------------------------------------------------------------------
interface nl_output_buffer_if;
    import parameters::*;

    logic  mem_wr_en;
    addr_t mem_wr_addr;
    word_t mem_wr_data;
    logic  mem_ready;

    modport master (
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data,
        input  mem_ready
    );

    modport slave (
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data,
        output mem_ready
    );

endinterface

// File: rtl/nl_outbuf_fifo.sv
// ----------------------------------------------------------------------------
// nl_outbuf_fifo -- synchronous FIFO of {word, producer address} entries.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   push, data_in,     store one entry (ignored when full)
//   addr_in
//   pop                remove the head entry (ignored when empty)
//   head_data,         current head entry (read combinationally, so a word
//   head_addr          pushed into an empty FIFO is visible the next cycle)
//   full, empty        occupancy status
// Pointers wrap naturally at NL_OUTBUF_DEPTH (power of two).
// ----------------------------------------------------------------------------
module nl_outbuf_fifo
    import parameters::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  word_t data_in,
    input  addr_t addr_in,
    output word_t head_data,
    output addr_t head_addr,
    output logic  full,
    output logic  empty
);

    word_t r_data_mem [NL_OUTBUF_DEPTH];
    addr_t r_addr_mem [NL_OUTBUF_DEPTH];

    logic [NL_OUTBUF_PTR_W-1:0] r_wr_ptr;
    logic [NL_OUTBUF_PTR_W-1:0] r_rd_ptr;
    logic [NL_OUTBUF_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // NOTE: the storage array has no reset; only pointers and occupancy do,
    // which already makes every stale entry unreachable and keeps the array
    // mappable onto plain RAM/flops without reset muxes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= data_in;
            r_addr_mem[r_wr_ptr] <= addr_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + NL_OUTBUF_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + NL_OUTBUF_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NL_OUTBUF_CNT_W'(1);
                2'b01:   r_count <= r_count - NL_OUTBUF_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full      = (r_count == NL_OUTBUF_CNT_W'(NL_OUTBUF_DEPTH));
    assign empty     = (r_count == '0);
    assign head_data = r_data_mem[r_rd_ptr];
    assign head_addr = r_addr_mem[r_rd_ptr];

endmodule

// File: rtl/nl_output_buffer.sv
// ----------------------------------------------------------------------------
// nl_output_buffer -- collects words from the nonlinear/pooling producer and
// drains them in order into activation memory at OUTPUT_BASE_ADDR + offset.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   enable_nonlinear_block     starts a pass (only honoured in IDLE)
//   wr_en_output_buffer_nl,    producer write: word and relative address
//   wr_addr_nl, output_word
//   finished_activation        producer has issued its last write
//   OUTPUT_BASE_ADDR           base of the result in activation memory
//   mem_bus (master)           mem_wr_en/addr/data out, mem_ready in
//   buffer_full, buffer_empty  FIFO status
//   overflow                   sticky: a write was dropped on a full FIFO
//   buffer_done                one-cycle pulse when the pass is drained
//
// Build option: define NL_OUTBUF_RELU_EN to clamp negative lanes to zero on
// the drain path (combinational, no extra latency).
// ----------------------------------------------------------------------------
module nl_output_buffer
    import parameters::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  enable_nonlinear_block,
    input  logic  wr_en_output_buffer_nl,
    input  addr_t wr_addr_nl,
    input  word_t output_word,
    input  logic  finished_activation,
    input  addr_t OUTPUT_BASE_ADDR,
    nl_output_buffer_if.master mem_bus,
    output logic  buffer_full,
    output logic  buffer_empty,
    output logic  overflow,
    output logic  buffer_done
);

    nl_state_t r_state;
    logic      r_overflow;

    logic  w_active;
    logic  w_push;
    logic  w_drop;
    logic  w_pop;
    logic  w_mem_wr_en;
    logic  w_full;
    logic  w_empty;
    word_t w_head_data;
    addr_t w_head_addr;
    word_t w_drain_data;

    assign w_active = (r_state == COLLECT) || (r_state == DRAIN);

    // Full is judged at cycle start: a pop in the same cycle does not make
    // room for the incoming word, which is dropped instead.
    assign w_push      = wr_en_output_buffer_nl && w_active && !w_full;
    assign w_drop      = wr_en_output_buffer_nl && w_active && w_full;
    assign w_mem_wr_en = w_active && !w_empty;
    assign w_pop       = w_mem_wr_en && mem_bus.mem_ready;

    nl_outbuf_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .data_in   (output_word),
        .addr_in   (wr_addr_nl),
        .head_data (w_head_data),
        .head_addr (w_head_addr),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (enable_nonlinear_block) begin
                        r_state    <= COLLECT;
                        r_overflow <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (finished_activation) r_state <= DRAIN;
                end
                DRAIN: begin
                    // A late write landing in an empty FIFO keeps us here.
                    if (w_empty && !w_push) r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef NL_OUTBUF_RELU_EN
    // NOTE: every variable written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_drain_data = w_head_data;
        for (int i = 0; i < N_DIM_ARRAY; i++) begin
            if (w_head_data[i][INPUT_CHANNEL_DATA_WIDTH-1]) w_drain_data[i] = '0;
        end
    end
`else
    assign w_drain_data = w_head_data;
`endif

    // Address and data are forced to zero whenever no write is requested, so
    // the bus never exposes stale or uninitialised storage. The sum wraps
    // modulo 2^INPUT_CHANNEL_ADDR_SIZE by construction.
    assign mem_bus.mem_wr_en   = w_mem_wr_en;
    assign mem_bus.mem_wr_addr = w_mem_wr_en ? addr_t'(OUTPUT_BASE_ADDR + w_head_addr) : '0;
    assign mem_bus.mem_wr_data = w_mem_wr_en ? w_drain_data : '0;

    assign buffer_full  = w_full;
    assign buffer_empty = w_empty;
    assign overflow     = r_overflow;
    assign buffer_done  = (r_state == DONE);

endmodule

// File: tb/tb_nl_output_buffer.sv
// ----------------------------------------------------------------------------
// tb_nl_output_buffer -- self-checking bench for nl_output_buffer.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_nl_output_buffer;
    import parameters::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  enable_nonlinear_block;
    logic  wr_en_output_buffer_nl;
    addr_t wr_addr_nl;
    word_t output_word;
    logic  finished_activation;
    addr_t OUTPUT_BASE_ADDR;
    logic  buffer_full;
    logic  buffer_empty;
    logic  overflow;
    logic  buffer_done;

    int n_checks = 0;
    int n_errors = 0;

    nl_output_buffer_if bus ();

    nl_output_buffer dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable_nonlinear_block (enable_nonlinear_block),
        .wr_en_output_buffer_nl (wr_en_output_buffer_nl),
        .wr_addr_nl             (wr_addr_nl),
        .output_word            (output_word),
        .finished_activation    (finished_activation),
        .OUTPUT_BASE_ADDR       (OUTPUT_BASE_ADDR),
        .mem_bus                (bus),
        .buffer_full            (buffer_full),
        .buffer_empty           (buffer_empty),
        .overflow               (overflow),
        .buffer_done            (buffer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       wr;
        logic       fin;
        logic [7:0] addr;
        int         lane0;
        logic       e_wen;
        logic [7:0] e_addr;
        int         e_lane0;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_done;
    } vec_t;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane 0 carries the test value; other lanes carry their index.
    function automatic word_t mk_word(input int l0);
        word_t w;
        w[0] = lane_t'(l0);
        for (int k = 1; k < N_DIM_ARRAY; k++) w[k] = lane_t'(k);
        return w;
    endfunction

    function automatic lane_t lane_out(input int k);
        return bus.mem_wr_data[k];
    endfunction

    task automatic idle_inputs();
        enable_nonlinear_block = 1'b0;
        wr_en_output_buffer_nl = 1'b0;
        finished_activation    = 1'b0;
        wr_addr_nl             = '0;
        output_word            = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic start_pass();
        enable_nonlinear_block = 1'b1;
        step();
        enable_nonlinear_block = 1'b0;
    endtask

    vec_t vecs[9];
    int   exp_idx;
    bit   done_seen;
    int   relu_exp;

    initial begin
        // Basic pass: three writes drained one cycle after each, one done pulse,
        // then a write in IDLE that must be ignored.
        //        en   wr   fin  addr  lane0  wen  addr   lane0 full empty ovf done
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 0,  1'b0, 8'h00, 0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'd0, 5,  1'b1, 8'h10, 5,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'd1, -3, 1'b1, 8'h11, -3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'd2, 7,  1'b1, 8'h12, 7,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd0, 0,  1'b0, 8'h00, 0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'd0, 0,  1'b0, 8'h00, 0,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd0, 0,  1'b0, 8'h00, 0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 8'd5, 9,  1'b0, 8'h00, 0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'd0, 0,  1'b0, 8'h00, 0,  1'b0, 1'b1, 1'b0, 1'b0};

        bus.mem_ready    = 1'b0;
        OUTPUT_BASE_ADDR = 8'h10;
        idle_inputs();
        reset = 1'b0;
        #1;
        check("reset_wen",   bus.mem_wr_en, 1'b0);
        check("reset_addr",  bus.mem_wr_addr, 0);
        check("reset_data",  (bus.mem_wr_data == '0), 1'b1);
        check("reset_full",  buffer_full, 1'b0);
        check("reset_empty", buffer_empty, 1'b1);
        check("reset_ovf",   overflow, 1'b0);
        check("reset_done",  buffer_done, 1'b0);
        step();
        reset = 1'b1;

        bus.mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            enable_nonlinear_block = vecs[i].en;
            wr_en_output_buffer_nl = vecs[i].wr;
            finished_activation    = vecs[i].fin;
            wr_addr_nl             = vecs[i].addr;
            output_word            = mk_word(vecs[i].lane0);
            step();
            check($sformatf("v%0d_wen", i),   bus.mem_wr_en, vecs[i].e_wen);
            if (vecs[i].e_wen) begin
                check($sformatf("v%0d_addr", i),  bus.mem_wr_addr, vecs[i].e_addr);
                check($sformatf("v%0d_lane0", i), lane_out(0), vecs[i].e_lane0);
            end
            check($sformatf("v%0d_full", i),  buffer_full, vecs[i].e_full);
            check($sformatf("v%0d_empty", i), buffer_empty, vecs[i].e_empty);
            check($sformatf("v%0d_ovf", i),   overflow, vecs[i].e_ovf);
            check($sformatf("v%0d_done", i),  buffer_done, vecs[i].e_done);
        end

        // Fill with memory stalled, overflow on the 9th write, then a push
        // against a full FIFO while it pops: push dropped, 8 ordered writes.
        do_reset();
        OUTPUT_BASE_ADDR = 8'h20;
        bus.mem_ready    = 1'b0;
        start_pass();
        for (int i = 0; i < 9; i++) begin
            wr_en_output_buffer_nl = 1'b1;
            wr_addr_nl             = addr_t'(i);
            output_word            = mk_word(i + 1);
            step();
            if (i == 0 || i == 8) begin
                check($sformatf("stall%0d_addr", i),  bus.mem_wr_addr, 8'h20);
                check($sformatf("stall%0d_lane0", i), lane_out(0), 1);
            end
            if (i == 6) check("fill7_full", buffer_full, 1'b0);
            if (i == 7) begin
                check("fill8_full", buffer_full, 1'b1);
                check("fill8_ovf",  overflow, 1'b0);
            end
            if (i == 8) begin
                check("fill9_full", buffer_full, 1'b1);
                check("fill9_ovf",  overflow, 1'b1);
            end
        end
        wr_addr_nl          = 8'd9;
        output_word         = mk_word(10);
        bus.mem_ready       = 1'b1;
        finished_activation = 1'b1;
        #1;
        exp_idx = 0;
        check("pp_wen",   bus.mem_wr_en, 1'b1);
        check("pp_addr",  bus.mem_wr_addr, 8'h20);
        check("pp_lane0", lane_out(0), 1);
        exp_idx = 1;
        step();
        wr_en_output_buffer_nl = 1'b0;
        finished_activation    = 1'b0;
        check("pp_full", buffer_full, 1'b0);
        check("pp_ovf",  overflow, 1'b1);
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 20 && !done_seen; cyc++) begin
            if (buffer_done) done_seen = 1'b1;
            else begin
                if (bus.mem_wr_en && bus.mem_ready) begin
                    check($sformatf("drain%0d_addr", exp_idx), bus.mem_wr_addr, 32'h20 + exp_idx);
                    check($sformatf("drain%0d_lane0", exp_idx), lane_out(0), exp_idx + 1);
                    exp_idx++;
                end
                step();
            end
        end
        check("drain_done_seen", done_seen, 1'b1);
        check("drain_count", exp_idx, 8);

        // Address wrap and lane clamping on the drain path.
        do_reset();
        OUTPUT_BASE_ADDR = 8'hFF;
        bus.mem_ready    = 1'b0;
        start_pass();
        wr_en_output_buffer_nl = 1'b1;
        wr_addr_nl             = 8'd2;
        output_word            = mk_word(-4);
        step();
        wr_en_output_buffer_nl = 1'b0;
`ifdef NL_OUTBUF_RELU_EN
        relu_exp = 0;
`else
        relu_exp = -4;
`endif
        check("wrap_wen",   bus.mem_wr_en, 1'b1);
        check("wrap_addr",  bus.mem_wr_addr, 8'h01);
        check("relu_lane0", lane_out(0), relu_exp);
        check("relu_lane1", lane_out(1), 1);

        // Reset in the middle of DRAIN with 4 entries held.
        do_reset();
        OUTPUT_BASE_ADDR = 8'h40;
        bus.mem_ready    = 1'b0;
        start_pass();
        for (int i = 0; i < 4; i++) begin
            wr_en_output_buffer_nl = 1'b1;
            wr_addr_nl             = addr_t'(i);
            output_word            = mk_word(i + 20);
            finished_activation    = (i == 3);
            step();
        end
        idle_inputs();
        check("mid_wen",   bus.mem_wr_en, 1'b1);
        check("mid_empty", buffer_empty, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mrst_wen",   bus.mem_wr_en, 1'b0);
        check("mrst_addr",  bus.mem_wr_addr, 0);
        check("mrst_data",  (bus.mem_wr_data == '0), 1'b1);
        check("mrst_full",  buffer_full, 1'b0);
        check("mrst_empty", buffer_empty, 1'b1);
        check("mrst_ovf",   overflow, 1'b0);
        check("mrst_done",  buffer_done, 1'b0);
        step();
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            step();
            check($sformatf("post_rst%0d_wen", cyc), bus.mem_wr_en, 1'b0);
        end
        check("post_rst_empty", buffer_empty, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
